pool_2d: RTL and testbench
==========================

POOL_2D -- requirements
Module: pool_2d

Interface
REQ-001 SHALL have parameter DWIDTH, 8, unsigned element width in bits.
REQ-002 SHALL have parameter NUM_LANES, 8, elements per input row (power of 2, >=4).
REQ-003 SHALL have parameter ROW_CNT_W, 8, width of the row counter and num_rows.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port enable_pool  input  1  1 = pooling, 0 = bypass.
REQ-007 SHALL have port pool_mode  input  1  0 = average, 1 = max.
REQ-008 SHALL have port kernel_size  input  3  pooling window edge K; legal values are 1, 2 and 4.
REQ-009 SHALL have port num_rows  input  ROW_CNT_W  number of input rows in the job.
REQ-010 SHALL have port in_data_available  input  1  inp_data valid this cycle.
REQ-011 SHALL have port inp_data  input  NUM_LANES*DWIDTH  one input row; lane i is in bits [i*DWIDTH +: DWIDTH].
REQ-012 SHALL have port out_data  output  NUM_LANES*DWIDTH  pooled row.
REQ-013 SHALL have port out_data_available  output  1  out_data valid.
REQ-014 SHALL have port done_pool  output  1  job complete.

Function
REQ-015 SHALL implement the states IDLE, ACCUM and DONE.
REQ-016 SHALL latch pool_mode, kernel_size and num_rows on the IDLE->ACCUM transition, which occurs in the first cycle enable_pool=1; mid-job changes to these inputs are ignored.
REQ-017 SHALL treat an illegal kernel_size (any value other than 1, 2 or 4) as K=1.
REQ-018 SHALL compute output lane j, for j < NUM_LANES/K, over a KxK window: input lanes j*K..j*K+K-1 of K consecutive valid rows.
REQ-019 SHALL drive output lanes j >= NUM_LANES/K to 0.
REQ-020 SHALL accept gaps in in_data_available; the window advances only on valid rows.
REQ-021 SHALL, in average mode, accumulate unsigned at DWIDTH+4 bits and output sum >> (2*log2 K), truncated.
REQ-022 SHALL, in max mode, output the unsigned maximum over the window.
REQ-023 SHALL register out_data and pulse out_data_available for exactly 1 cycle, 1 cycle after the K-th valid row of each window.
REQ-024 SHALL hold out_data between pulses.
REQ-025 SHALL clear the accumulators in the same cycle the result is registered, so that back-to-back windows need no bubble.
REQ-026 SHALL increment the row counter on each valid row.
REQ-027 SHALL go ACCUM->DONE when the counter reaches the latched num_rows.
REQ-028 SHALL, if num_rows is not a multiple of K, emit the final partial window using the average divisor of the full window.
REQ-029 SHALL treat num_rows=0 as ACCUM->DONE in the next cycle with no output.
REQ-030 SHALL, in DONE, hold done_pool=1 and ignore input rows.
REQ-031 SHALL return to IDLE from any state when enable_pool=0, clearing the counters, accumulators and done_pool.
REQ-032 SHALL provide combinational bypass while enable_pool=0: out_data=inp_data, out_data_available=in_data_available, done_pool=1.

Reset
REQ-033 SHALL, when resetn=0 at a clock edge, enter IDLE and clear all state: out_data register 0, out_data_available 0, done_pool register 0, row counter 0, accumulators 0.
REQ-034 SHALL let reset override an operation in progress; no output pulse is produced for a partial window.
REQ-035 SHALL make the output ports follow the bypass rule of REQ-032 when enable_pool=0, including during reset.

Structure
REQ-036 SHALL place the state encoding, the pool_mode encoding, the legal K constants and the accumulator-width constant in the shared package pool_pkg.
REQ-037 SHALL instantiate NUM_LANES copies of the sub-module pool_lane, each a K-wide horizontal reducer with vertical accumulator and a sum/max select.
REQ-038 SHALL keep control (FSM, counters, config latch) in pool_2d.

Verification
REQ-039 SHALL cover: NUM_LANES=8, avg, K=2, rows [10,20,30,40,...] then [30,40,50,60,...] -> lane0 = (10+20+30+40)>>2 = 25, one-cycle pulse after row 2, lanes 4-7 = 0.
REQ-040 SHALL cover: max, K=4, 4 rows with the value 200 at row 3 lane 1 -> lane0 = 200, single pulse after row 4.
REQ-041 SHALL cover: avg, K=2, num_rows=4, rows with in_data_available gaps of 3 cycles -> exactly 2 pulses, then done_pool=1 one cycle after row 4.
REQ-042 SHALL cover: avg, K=4, all lanes 255 -> lane0 = 255 (no overflow, 12-bit accumulate).
REQ-043 SHALL cover: resetn=0 after row 1 of a K=2 window -> no pulse, outputs cleared, next job correct from row 0.
REQ-044 SHALL cover: enable_pool=0, inp_data=0x0102..08 with valid=1 -> out_data identical the same cycle, done_pool=1; kernel_size=3 behaves as K=1.

Source files
------------

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and constants for the 2-D pooling block
// Purpose: FSM state encoding, pool mode encoding, legal window sizes,
//          accumulator growth and the window-size decode helper.
// Ports:   none (package).
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } pool_state_e;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  localparam logic [2:0] K_1 = 3'd1;
  localparam logic [2:0] K_2 = 3'd2;
  localparam logic [2:0] K_4 = 3'd4;

  // A 4x4 window of DWIDTH-bit values needs 4 extra bits of sum headroom.
  localparam int ACC_GROWTH = 4;

  // log2 of the window edge; anything other than 2 or 4 falls back to K=1.
  function automatic logic [1:0] k_log2(input logic [2:0] k);
    case (k)
      K_2:     return 2'd1;
      K_4:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_2d_if.sv
// rtl/pool_2d_if.sv - row stream and status bundle of the pooling block
// Purpose: groups the input row handshake, the pooled row output and done.
// Ports:   in_data_available/inp_data  row in (master -> slave)
//          out_data/out_data_available pooled row out (slave -> master)
//          done_pool                   job complete (slave -> master)
interface pool_2d_if #(
  parameter int DWIDTH    = 8,
  parameter int NUM_LANES = 8
);
  logic                          in_data_available;
  logic [NUM_LANES*DWIDTH-1:0]   inp_data;
  logic [NUM_LANES*DWIDTH-1:0]   out_data;
  logic                          out_data_available;
  logic                          done_pool;

  modport master (
    output in_data_available, inp_data,
    input  out_data, out_data_available, done_pool
  );

  modport slave (
    input  in_data_available, inp_data,
    output out_data, out_data_available, done_pool
  );
endinterface

// File: rtl/pool_lane.sv
// rtl/pool_lane.sv - one output lane: horizontal reduce plus vertical accumulate
// Purpose: reduces up to K input elements of a row (sum or max), folds them
//          into a vertical accumulator and registers the window result.
// Ports:   clk/resetn      clock, synchronous active-low reset
//          clear           drop accumulated state (job aborted)
//          row_valid       a row is accepted this cycle
//          win_close       this row completes the window
//          mode/k_log      latched pool mode and log2 of window edge
//          active          lane lies inside NUM_LANES/K, else result is 0
//          elems           the (up to) four input elements feeding this lane
//          result          registered pooled element
module pool_lane
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int ACC_W  = DWIDTH + ACC_GROWTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   row_valid,
  input  logic                   win_close,
  input  pool_mode_e             mode,
  input  logic [1:0]             k_log,
  input  logic                   active,
  input  logic [3:0][DWIDTH-1:0] elems,
  output logic [DWIDTH-1:0]      result
);

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  hsum;
  logic [ACC_W-1:0]  vsum;
  logic [DWIDTH-1:0] hmax;
  logic [DWIDTH-1:0] vmax;
  logic [DWIDTH-1:0] avg_out;
  logic [3:0]        k_mask;

  always_comb begin
    case (k_log)
      2'd1:    k_mask = 4'b0011;
      2'd2:    k_mask = 4'b1111;
      default: k_mask = 4'b0001;
    endcase
    hsum = '0;
    hmax = '0;
    for (int e = 0; e < 4; e++) begin
      if (k_mask[e]) begin
        hsum = hsum + ACC_W'(elems[e]);
        if (elems[e] > hmax) hmax = elems[e];
      end
    end
    vsum = acc_q + hsum;
    // In max mode the accumulator only ever holds a DWIDTH-bit value.
    vmax = (acc_q[DWIDTH-1:0] > hmax) ? acc_q[DWIDTH-1:0] : hmax;
    // Divisor is always the full K*K, also for a short final window.
    avg_out = DWIDTH'(vsum >> {k_log, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q  <= '0;
      result <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (row_valid) begin
      if (win_close) begin
        // Result capture and accumulator clear share the cycle, so the
        // next window can start on the very next row.
        result <= active ? ((mode == POOL_MAX) ? vmax : avg_out) : '0;
        acc_q  <= '0;
      end else begin
        acc_q <= (mode == POOL_MAX) ? ACC_W'(vmax) : vsum;
      end
    end
  end

endmodule

// File: rtl/pool_2d.sv
// rtl/pool_2d.sv - 2-D average/max pooling over a stream of rows
// Purpose: control (FSM, row/window counters, config latch) around NUM_LANES
//          pool_lane reducers, with combinational bypass when disabled.
// Ports:   clk/resetn      clock, synchronous active-low reset
//          enable_pool     1 = pooling, 0 = bypass (and return to IDLE)
//          pool_mode       0 = average, 1 = max
//          kernel_size     window edge K (1, 2, 4; others act as 1)
//          num_rows        rows in the job
//          bus             row stream in, pooled rows and done out
module pool_2d
  import pool_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int NUM_LANES = 8,
  parameter int ROW_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable_pool,
  input  logic                 pool_mode,
  input  logic [2:0]           kernel_size,
  input  logic [ROW_CNT_W-1:0] num_rows,
  pool_2d_if.slave             bus
);

  pool_state_e            state_q, state_d;
  pool_mode_e             mode_q;
  logic [1:0]             klog_q;
  logic [ROW_CNT_W-1:0]   num_rows_q;
  logic [ROW_CNT_W-1:0]   row_cnt_q;
  logic [1:0]             win_cnt_q;
  logic                   out_valid_q;

  logic [ROW_CNT_W:0]     row_cnt_inc;
  logic                   last_row;
  logic [1:0]             win_last;
  logic                   row_accept;
  logic                   win_close;
  logic                   job_done;

  // Extra bit so the compare never wraps at the top of the counter range.
  assign row_cnt_inc = {1'b0, row_cnt_q} + {{ROW_CNT_W{1'b0}}, 1'b1};
  assign last_row    = (row_cnt_inc == {1'b0, num_rows_q});
  assign win_last    = (klog_q == 2'd2) ? 2'd3 : ((klog_q == 2'd1) ? 2'd1 : 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable_pool) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ACCUM;
        ST_ACCUM: if (job_done) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    row_accept = (state_q == ST_ACCUM) && enable_pool && bus.in_data_available;
    // A window also closes on the job's last row, giving the partial window.
    win_close  = row_accept && ((win_cnt_q == win_last) || last_row);
    // num_rows == 0 finishes on the first ACCUM cycle without any row.
    job_done   = (state_q == ST_ACCUM) &&
                 ((row_cnt_q == num_rows_q) || (row_accept && last_row));
  end

  // Config is captured once per job, on leaving IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q     <= POOL_AVG;
      klog_q     <= 2'd0;
      num_rows_q <= '0;
    end else if (state_q == ST_IDLE && enable_pool) begin
      mode_q     <= pool_mode_e'(pool_mode);
      klog_q     <= k_log2(kernel_size);
      num_rows_q <= num_rows;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || !enable_pool) begin
      row_cnt_q   <= '0;
      win_cnt_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= win_close;
      if (row_accept) begin
        row_cnt_q <= row_cnt_q + 1'b1;
        win_cnt_q <= win_close ? 2'd0 : win_cnt_q + 2'd1;
      end
    end
  end

  // Zero-padded copy of the input row so every lane can index 4*j+3 safely.
  logic [DWIDTH-1:0]                 lane_pad [4*NUM_LANES];
  logic [NUM_LANES-1:0][DWIDTH-1:0]  lane_res;

  for (genvar i = 0; i < 4*NUM_LANES; i++) begin : g_pad
    if (i < NUM_LANES) begin : g_real
      assign lane_pad[i] = bus.inp_data[i*DWIDTH +: DWIDTH];
    end else begin : g_zero
      assign lane_pad[i] = '0;
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic [3:0][DWIDTH-1:0] elems;
    logic                   active;

    always_comb begin
      elems = '0;
      case (klog_q)
        2'd1: begin
          elems[0] = lane_pad[2*j];
          elems[1] = lane_pad[2*j+1];
        end
        2'd2: begin
          for (int e = 0; e < 4; e++) elems[e] = lane_pad[4*j+e];
        end
        default: elems[0] = lane_pad[j];
      endcase
    end

    assign active = (32'(j) < (32'(NUM_LANES) >> klog_q));

    pool_lane #(
      .DWIDTH (DWIDTH)
    ) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (!enable_pool),
      .row_valid (row_accept),
      .win_close (win_close),
      .mode      (mode_q),
      .k_log     (klog_q),
      .active    (active),
      .elems     (elems),
      .result    (lane_res[j])
    );
  end

  // Bypass is purely combinational and takes effect even during reset.
  assign bus.out_data           = enable_pool ? lane_res : bus.inp_data;
  assign bus.out_data_available = enable_pool ? out_valid_q : bus.in_data_available;
  assign bus.done_pool          = enable_pool ? (state_q == ST_DONE) : 1'b1;

endmodule

// File: tb/tb_pool_2d.sv
// tb/tb_pool_2d.sv - directed self-checking bench for pool_2d
module tb_pool_2d;

  localparam int DW = 8;
  localparam int NL = 8;
  localparam int RW = 8;
  localparam int W  = DW * NL;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable_pool;
  logic          pool_mode;
  logic [2:0]    kernel_size;
  logic [RW-1:0] num_rows;

  pool_2d_if #(.DWIDTH(DW), .NUM_LANES(NL)) bus ();

  pool_2d #(
    .DWIDTH    (DW),
    .NUM_LANES (NL),
    .ROW_CNT_W (RW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable_pool (enable_pool),
    .pool_mode   (pool_mode),
    .kernel_size (kernel_size),
    .num_rows    (num_rows),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] job_rows [$];
  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: straightforward per-lane loop over the window, divisor K*K.
  function automatic logic [W-1:0] ref_window(input int first, input int cnt,
                                              input int k, input bit mx);
    logic [W-1:0] r;
    logic [W-1:0] row;
    int s, m, v;
    r = '0;
    for (int j = 0; j < NL / k; j++) begin
      s = 0;
      m = 0;
      for (int rr = first; rr < first + cnt; rr++) begin
        row = job_rows[rr];
        for (int e = 0; e < k; e++) begin
          v = int'(row[(j*k+e)*DW +: DW]);
          s += v;
          if (v > m) m = v;
        end
      end
      r[j*DW +: DW] = mx ? DW'(m) : DW'(s / (k * k));
    end
    return r;
  endfunction

  // Scoreboard: every pooled pulse pops one expected row.
  always @(posedge clk) begin
    #1;
    if (enable_pool && bus.out_data_available) begin
      n_pulse++;
      check("pulse_expected", W'(exp_q.size() > 0), W'(1));
      if (exp_q.size() > 0) check("pulse_data", bus.out_data, exp_q.pop_front());
    end
  end

  task automatic fill_random(input int n, input int maxv);
    logic [W-1:0] row;
    job_rows.delete();
    for (int r = 0; r < n; r++) begin
      for (int l = 0; l < NL; l++) row[l*DW +: DW] = DW'($urandom_range(maxv, 0));
      job_rows.push_back(row);
    end
  endtask

  task automatic run_job(input bit mx, input logic [2:0] ksz, input int nrows, input int gap);
    int k, p0, nwin, first;
    bit closes;
    k = (ksz == 3'd2) ? 2 : ((ksz == 3'd4) ? 4 : 1);
    @(negedge clk);
    pool_mode   = mx;
    kernel_size = ksz;
    num_rows    = RW'(nrows);
    bus.in_data_available = 1'b0;
    enable_pool = 1'b1;
    @(negedge clk);
    // Mid-job config changes must be ignored.
    pool_mode   = ~mx;
    kernel_size = (k == 2) ? 3'd4 : 3'd2;
    num_rows    = RW'(nrows + 3);
    p0 = n_pulse;
    for (int r = 0; r < nrows; r++) begin
      bus.inp_data = job_rows[r];
      bus.in_data_available = 1'b1;
      closes = ((r + 1) % k == 0) || (r + 1 == nrows);
      first  = r - (r % k);
      if (closes) exp_q.push_back(ref_window(first, r % k + 1, k, mx));
      @(posedge clk);
      #1;
      check($sformatf("pulse_timing_row%0d", r), W'(bus.out_data_available), W'(closes));
      if (r == nrows - 1) check("done_after_last_row", W'(bus.done_pool), W'(1));
      bus.in_data_available = 1'b0;
      @(negedge clk);
      repeat (gap) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    nwin = (nrows + k - 1) / k;
    check("pulse_count", W'(n_pulse - p0), W'(nwin));
    check("done_hold", W'(bus.done_pool), W'(1));
    check("queue_drained", W'(exp_q.size()), W'(0));
    // Rows arriving in DONE are ignored.
    bus.inp_data = {NL{8'hA5}};
    bus.in_data_available = 1'b1;
    @(posedge clk);
    #1;
    check("done_ignores_row", W'(bus.out_data_available), W'(0));
    bus.in_data_available = 1'b0;
  endtask

  task automatic stop_job();
    @(negedge clk);
    enable_pool = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] row;
    int p0;

    resetn      = 1'b0;
    enable_pool = 1'b1;
    pool_mode   = 1'b0;
    kernel_size = 3'd2;
    num_rows    = '0;
    bus.in_data_available = 1'b0;
    bus.inp_data = '0;

    // Reset state with pooling enabled: registered outputs are cleared.
    repeat (2) @(negedge clk);
    check("reset_out_data", bus.out_data, '0);
    check("reset_out_valid", W'(bus.out_data_available), W'(0));
    check("reset_done", W'(bus.done_pool), W'(0));

    // Bypass follows the inputs combinationally, even while in reset.
    enable_pool = 1'b0;
    bus.inp_data = 64'h0102030405060708;
    bus.in_data_available = 1'b1;
    #1;
    check("bypass_data", bus.out_data, 64'h0102030405060708);
    check("bypass_valid", W'(bus.out_data_available), W'(1));
    check("bypass_done", W'(bus.done_pool), W'(1));
    bus.in_data_available = 1'b0;
    #1;
    check("bypass_valid_low", W'(bus.out_data_available), W'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Average, K=2: lane0 = (10+20+30+40)>>2 = 25, lanes 4-7 zero.
    job_rows.delete();
    for (int l = 0; l < NL; l++) row[l*DW +: DW] = DW'(10 * (l + 1));
    job_rows.push_back(row);
    for (int l = 0; l < NL; l++) row[l*DW +: DW] = DW'(10 * (l + 3));
    job_rows.push_back(row);
    run_job(1'b0, 3'd2, 2, 0);
    check("avg_k2_lane0", W'(bus.out_data[7:0]), W'(25));
    check("avg_k2_upper_zero", W'(bus.out_data[63:32]), W'(0));
    stop_job();

    // Max, K=4, peak of 200 inside the window.
    fill_random(4, 100);
    row = job_rows[2];
    row[15:8] = 8'd200;
    job_rows[2] = row;
    run_job(1'b1, 3'd4, 4, 0);
    check("max_k4_lane0", W'(bus.out_data[7:0]), W'(200));
    stop_job();

    // Average, K=2, gaps of 3 cycles between rows.
    fill_random(4, 255);
    run_job(1'b0, 3'd2, 4, 3);
    stop_job();

    // Average, K=4, saturated input must not overflow.
    job_rows.delete();
    repeat (4) job_rows.push_back({NL{8'hFF}});
    run_job(1'b0, 3'd4, 4, 0);
    check("avg_k4_all_255", bus.out_data, 64'h0000_0000_0000_FFFF);
    stop_job();

    // Reset after the first row of a K=2 window: no pulse, outputs cleared.
    fill_random(2, 255);
    @(negedge clk);
    pool_mode   = 1'b0;
    kernel_size = 3'd2;
    num_rows    = RW'(4);
    enable_pool = 1'b1;
    @(negedge clk);
    p0 = n_pulse;
    bus.inp_data = job_rows[0];
    bus.in_data_available = 1'b1;
    @(negedge clk);
    bus.in_data_available = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out_valid", W'(bus.out_data_available), W'(0));
    check("midreset_out_data", bus.out_data, '0);
    check("midreset_done", W'(bus.done_pool), W'(0));
    @(negedge clk);
    resetn = 1'b1;
    enable_pool = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_no_pulse", W'(n_pulse - p0), W'(0));
    fill_random(4, 255);
    run_job(1'b0, 3'd2, 4, 0);
    stop_job();

    // Illegal kernel_size 3 acts as K=1: each row passes through.
    fill_random(3, 255);
    run_job(1'b0, 3'd3, 3, 1);
    check("k3_as_k1_last_row", bus.out_data, job_rows[2]);
    stop_job();

    // Partial final windows keep the full-window divisor.
    fill_random(6, 255);
    run_job(1'b0, 3'd4, 6, 0);
    stop_job();
    fill_random(5, 255);
    run_job(1'b1, 3'd2, 5, 2);
    stop_job();

    // num_rows = 0: straight to DONE with no output.
    job_rows.delete();
    run_job(1'b0, 3'd2, 0, 0);
    stop_job();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
